// File: rtl/seq_approx_div_pkg.sv
// seq_approx_div_pkg: shared FSM states, subtractor cells and approximation mask helper
package seq_approx_div_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  function automatic logic [1:0] exact_cell(input logic x, input logic y, input logic bin);
    return {x ^ y ^ bin, (~x & y) | (~(x ^ y) & bin)};
  endfunction
  function automatic logic [1:0] approx_cell(input logic x, input logic y, input logic bin);
    return {(~x & y) | (x & ~y & ~bin) | (x & y & bin), (~x & y) | (x & y & bin)};
  endfunction
  // Triangular region: column j of row k is approximate while k+j < lvl; callers truncate to DW.
  function automatic logic [63:0] approx_mask(input int k, input int lvl);
    logic [63:0] m;
    for (int j = 0; j < 64; j++) m[j] = (k + j < lvl);
    return m;
  endfunction
endpackage

// File: rtl/div_sub_row.sv
// div_sub_row: one DW-column borrow-chain subtractor row with per-column approximate cells
module div_sub_row
  import seq_approx_div_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [DW-1:0] x,
  input  logic [DW-1:0] y,
  input  logic [DW-1:0] mask,
  output logic [DW-1:0] diff,
  output logic          bout
);
  logic [DW:0] b;
  assign b[0] = 1'b0;
  for (genvar j = 0; j < DW; j++) begin : g_col
    assign {diff[j], b[j+1]} = mask[j] ? approx_cell(x[j], y[j], b[j]) : exact_cell(x[j], y[j], b[j]);
  end
  assign bout = b[DW];
endmodule

// File: rtl/seq_approx_divider.sv
// seq_approx_divider: iterative restoring divider, one quotient bit per cycle, run-time approximation depth
module seq_approx_divider
  import seq_approx_div_pkg::*;
#(
  parameter int DW      = 8,
  parameter int MAX_LVL = 4,
  parameter int LVL_W   = $clog2(2 * DW)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*DW-1:0] n,
  input  logic [DW-1:0]   d,
  input  logic [LVL_W-1:0] approx_lvl,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   q,
  output logic [DW-1:0]   r,
  output logic            dbz,
  output logic            ovf
);
  localparam int KW = $clog2(DW);
  state_t st;
  logic [DW-1:0] d_q, rem, qr, rr, diff, nr, mask;
  logic [DW-2:0] n_sh;
  logic [KW-1:0] k;
  logic [LVL_W-1:0] lvl, lvl_c;
  logic spill, bout, qb, dbz_q, ovf_q;
  div_sub_row #(.DW(DW)) u_row (.x(rem), .y(d_q), .mask(mask), .diff(diff), .bout(bout));
  assign mask = DW'(approx_mask(int'(k), int'(lvl)));
  assign lvl_c = (approx_lvl > LVL_W'(MAX_LVL)) ? LVL_W'(MAX_LVL) : approx_lvl;
  assign qb = spill | ~bout;
  assign nr = qb ? diff : rem;
  assign in_ready = (st == IDLE);
  assign out_valid = (st == DONE);
  assign q = qr;
  assign r = rr;
  assign dbz = dbz_q;
  assign ovf = ovf_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      {d_q, rem, qr, rr, n_sh, k, lvl, spill, dbz_q, ovf_q} <= '0;
    end else if (st == IDLE && in_valid) begin
      st    <= RUN;
      d_q   <= d;
      lvl   <= lvl_c;
      dbz_q <= (d == '0);
      ovf_q <= (n[2*DW-1:DW] >= d);
      rem   <= n[2*DW-2:DW-1];
      spill <= n[2*DW-1];
      n_sh  <= n[DW-2:0];
      k     <= KW'(DW - 1);
      qr    <= '0;
    end else if (st == RUN) begin
      qr[k] <= qb;
      if (k == '0) begin
        rr <= nr;
        st <= DONE;
      end else begin
        spill <= nr[DW-1];
        rem   <= {nr[DW-2:0], n_sh[DW-2]};
        n_sh  <= n_sh << 1;
        k     <= k - KW'(1);
      end
    end else if (st == DONE && out_ready) begin
      st <= IDLE;
    end
  end
endmodule

// File: tb/tb_seq_approx_divider.sv
// tb_seq_approx_divider: directed and model-checked scenarios for seq_approx_divider (DW=8, MAX_LVL=4)
module tb_seq_approx_divider;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid, dbz, ovf;
  logic [15:0] n = '0;
  logic [7:0] d = '0, q, r;
  logic [3:0] approx_lvl = '0;
  int checks = 0, failures = 0;

  seq_approx_divider #(.DW(8), .MAX_LVL(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .n(n), .d(d),
    .approx_lvl(approx_lvl), .out_valid(out_valid), .out_ready(out_ready),
    .q(q), .r(r), .dbz(dbz), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Triangular array reference: cells patched where approximation changes the truth table.
  function automatic logic [15:0] model(input logic [15:0] nn, input logic [7:0] dd, input int lv);
    logic [7:0] rm, qq, df;
    logic sp, b, x, y, db, bo;
    rm = nn[14:7];
    sp = nn[15];
    qq = '0;
    for (int k = 7; k >= 0; k--) begin
      b = 0;
      for (int j = 0; j < 8; j++) begin
        x = rm[j];
        y = dd[j];
        db = x ^ y ^ b;
        bo = (!x && y) || (!(x ^ y) && b);
        if (k + j < lv && !x && b) begin
          if (!y) begin db = 0; bo = 0; end
          else db = 1;
        end
        df[j] = db;
        b = bo;
      end
      qq[k] = sp | ~b;
      if (qq[k]) rm = df;
      if (k > 0) begin
        sp = rm[7];
        rm = {rm[6:0], nn[k-1]};
      end
    end
    return {qq, rm};
  endfunction

  task automatic do_op(input logic [15:0] nn, input logic [7:0] dd, input logic [3:0] lv, output int lat);
    int t = 0;
    while (!in_ready && t < 50) begin @(posedge clk); #1; t++; end
    n = nn; d = dd; approx_lvl = lv; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    lat = 1;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    if (!out_valid) begin
      checks++; failures++;
      $display("FAIL timeout n=%h d=%h: out_valid never rose", nn, dd);
    end
  endtask

  task automatic release_out();
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, q, r, dbz, ovf} !== {1'b1, 1'b0, 8'h0, 8'h0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset: got rdy=%b ov=%b q=%h r=%h dbz=%b ovf=%b want rdy=1 ov=0 q=0 r=0 dbz=0 ovf=0",
               in_ready, out_valid, q, r, dbz, ovf);
    end
    rst = 0;
  endtask

  task automatic test_exact();
    int lat;
    do_op(16'd100, 8'd7, 4'd0, lat);
    checks++;
    if (lat !== 9) begin failures++; $display("FAIL latency: got %0d want 9", lat); end
    checks++;
    if ({q, r, dbz, ovf} !== {8'd14, 8'd2, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL exact_100_7: got q=%0d r=%0d dbz=%b ovf=%b want q=14 r=2 dbz=0 ovf=0", q, r, dbz, ovf);
    end
    release_out();
  endtask

  task automatic test_approx();
    int lat;
    do_op(16'h0004, 8'h01, 4'd2, lat);
    checks++;
    if ({q, r} !== {8'h05, 8'h01}) begin
      failures++;
      $display("FAIL approx_lvl2: got q=%h r=%h want q=05 r=01", q, r);
    end
    release_out();
    do_op(16'h0004, 8'h01, 4'd0, lat);
    checks++;
    if ({q, r} !== {8'h04, 8'h00}) begin
      failures++;
      $display("FAIL approx_lvl0: got q=%h r=%h want q=04 r=00", q, r);
    end
    release_out();
  endtask

  task automatic test_clamp();
    int lat, bad = 0;
    logic [15:0] nn, e;
    logic [7:0] dd;
    logic [15:0] g15, g4;
    for (int i = 0; i < 1000; i++) begin
      nn = 16'($urandom_range(0, 65535));
      dd = 8'($urandom_range(0, 255));
      e = model(nn, dd, 4);
      do_op(nn, dd, 4'd15, lat);
      g15 = {q, r};
      release_out();
      do_op(nn, dd, 4'd4, lat);
      g4 = {q, r};
      release_out();
      checks++;
      if (g15 !== e || g4 !== e) begin
        failures++;
        if (bad < 5)
          $display("FAIL clamp n=%h d=%h: lvl15 q/r=%h lvl4 q/r=%h want %h", nn, dd, g15, g4, e);
        bad++;
      end
    end
  endtask

  task automatic test_dbz();
    int lat;
    do_op(16'h1234, 8'h00, 4'd0, lat);
    checks++;
    if ({q, r, dbz, ovf} !== {8'hFF, 8'h34, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL dbz: got q=%h r=%h dbz=%b ovf=%b want q=ff r=34 dbz=1 ovf=1", q, r, dbz, ovf);
    end
    release_out();
  endtask

  task automatic test_ovf();
    int lat;
    logic [15:0] e;
    e = model(16'hFFFF, 8'h01, 0);
    do_op(16'hFFFF, 8'h01, 4'd0, lat);
    checks++;
    if ({q, r, dbz, ovf} !== {e, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL ovf: got q=%h r=%h dbz=%b ovf=%b want q=%h r=%h dbz=0 ovf=1", q, r, dbz, ovf, e[15:8], e[7:0]);
    end
    release_out();
  endtask

  task automatic test_hold();
    int lat;
    do_op(16'd200, 8'd9, 4'd0, lat);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({out_valid, in_ready, q, r} !== {1'b1, 1'b0, 8'd22, 8'd2}) begin
        failures++;
        $display("FAIL hold cyc%0d: got ov=%b rdy=%b q=%0d r=%0d want ov=1 rdy=0 q=22 r=2", i, out_valid, in_ready, q, r);
      end
      @(posedge clk); #1;
    end
    release_out();
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      failures++;
      $display("FAIL hold_release: got rdy=%b ov=%b want rdy=1 ov=0", in_ready, out_valid);
    end
  endtask

  task automatic test_busy_ignore();
    int t = 0;
    n = 16'd50; d = 8'd5; approx_lvl = 0; in_valid = 1;
    @(posedge clk); #1;
    n = 16'd999; d = 8'd3;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 0;
    while (!out_valid && t < 40) begin @(posedge clk); #1; t++; end
    checks++;
    if ({out_valid, q, r} !== {1'b1, 8'd10, 8'd0}) begin
      failures++;
      $display("FAIL busy_ignore: got ov=%b q=%0d r=%0d want ov=1 q=10 r=0", out_valid, q, r);
    end
    release_out();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      failures++;
      $display("FAIL busy_not_consumed: got rdy=%b ov=%b want rdy=1 ov=0", in_ready, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [15:0] ns [3] = '{16'd1000, 16'd65000, 16'd255};
    logic [7:0] ds [3] = '{8'd33, 8'd255, 8'd1};
    logic [15:0] es [3] = '{{8'd30, 8'd10}, {8'd254, 8'd230}, {8'd255, 8'd0}};
    for (int i = 0; i < 3; i++) begin
      do_op(ns[i], ds[i], 4'd0, lat);
      checks++;
      if ({q, r} !== es[i]) begin
        failures++;
        $display("FAIL b2b%0d: got q=%0d r=%0d want q=%0d r=%0d", i, q, r, es[i][15:8], es[i][7:0]);
      end
      release_out();
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    n = 16'd5000; d = 8'd77; approx_lvl = 0; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      failures++;
      $display("FAIL reset_mid: got ov=%b rdy=%b want ov=0 rdy=1", out_valid, in_ready);
    end
    do_op(16'd77, 8'd4, 4'd0, lat);
    checks++;
    if ({q, r} !== {8'd19, 8'd1}) begin
      failures++;
      $display("FAIL after_reset: got q=%0d r=%0d want q=19 r=1", q, r);
    end
    release_out();
  endtask

  initial begin
    test_reset();
    test_exact();
    test_approx();
    test_dbz();
    test_ovf();
    test_hold();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    test_clamp();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/seq_approx_divider.md
Name: seq_approx_divider

Overview:
- Iterative restoring divider with a valid/ready handshake. It produces one quotient bit per clock, MSB first.
- It is the sequential, parametrised successor of the combinational 16/8 triangular approximate array divider.
- The approximation depth is selectable per transaction at run time, from exact (0) up to a build-time maximum.
- It is bit-true to the triangular array model at the same width and depth, and adds divide-by-zero and overflow flags.

Parameters:
- DW, 8, divisor/quotient/remainder width; dividend is 2*DW bits.
- MAX_LVL, 4, largest approximation depth honoured; larger requests are clamped.
- LVL_W, $clog2(2*DW), width of the approx_lvl port.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operands valid
- in_ready  out  1  block accepts operands
- n  in  2*DW  dividend
- d  in  DW  divisor
- approx_lvl  in  LVL_W  requested approximation depth
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- q  out  DW  quotient
- r  out  DW  remainder
- dbz  out  1  divisor was zero
- ovf  out  1  n[2DW-1:DW] >= d, so the true quotient does not fit in DW bits

Behaviour:
- Single clock domain; reset is synchronous and active-high.
- Reset values: in_ready=1, out_valid=0, q=0, r=0, dbz=0, ovf=0, FSM in IDLE. A reset mid-operation aborts the division and discards the result.
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&in_ready, latch n, d, lvl=min(approx_lvl,MAX_LVL), dbz=(d==0), ovf=(n[2DW-1:DW]>=d). Initialise rem=n[2DW-2:DW-1], spill=n[2DW-1], k=DW-1. Go to RUN.
- RUN: in_ready=0. Each cycle, compute step k:
  - The DW-bit borrow chain computes rem - d, bin=0 into column 0.
  - Column j uses the approximate cell when k+j < lvl, otherwise the exact cell.
  - q[k] = spill | ~bout_final.
  - nr = q[k] ? diff : rem.
  - If k>0: spill=nr[DW-1], rem={nr[DW-2:0], n[k-1]}, k=k-1.
  - If k==0: r=nr, go to DONE.
- Latency: DW cycles in RUN. out_valid rises on the cycle after the k=0 step, i.e. DW+1 cycles after acceptance.
- DONE: out_valid=1. q, r, dbz and ovf are held stable while out_ready=0. On out_ready, go to IDLE; in_ready returns to 1 the following cycle. There is no overlap between transactions.
- Exact cell: diff=x^y^bin; bout=(~x&y)|(~(x^y)&bin).
- Approximate cell: diff=(~x&y)|(x&~y&~bin)|(x&y&bin); bout=(~x&y)|(x&y&bin).
  - It differs from the exact cell only at (x,y,bin)=(0,0,1), where diff=0 and bout=0, and at (0,1,1), where diff=1.
- lvl=0 gives exact restoring division whenever ovf=0.
- d=0: no special path. The computation runs normally; with lvl=0 this gives q=all ones and r=n[DW-1:0], with dbz=1.
- ovf=1: q and r are whatever the array model computes, truncated to DW bits. The flag is informational only.
- in_valid while busy is ignored; the operands are not consumed.

Decomposition:
- Package seq_approx_div_pkg holds:
  - the state enum;
  - the functions exact_cell and approx_cell, returning {diff,bout};
  - the function approx_mask(k,lvl), which returns the DW-bit column-enable mask.
- Sub-module div_sub_row holds the combinational DW-column borrow chain with a per-column approx mask input and outputs diff[DW-1:0] and bout_final.
- The top level holds the FSM, the step counter and the rem/spill/q/r registers.

Test Plan:
- Reset and exact division: after reset, check in_ready=1 and out_valid=0. Then n=100, d=7, lvl=0 -> q=14, r=2, dbz=0, ovf=0, with out_valid asserted exactly 9 cycles after acceptance.
- Approximation effect: n=0x0004, d=0x01, lvl=2 -> q=0x05, r=0x01. The same operands with lvl=0 -> q=0x04, r=0x00.
- Clamping: approx_lvl=15 with MAX_LVL=4 must give results identical to approx_lvl=4 over 1000 random operands, checked against a golden array model.
- Divide by zero: n=0x1234, d=0, lvl=0 -> dbz=1, q=0xFF, r=0x34. Overflow: n=0xFFFF, d=0x01 -> ovf=1, q/r equal to the golden model.
- Handshake:
  - Hold out_ready=0 for 5 cycles in DONE; outputs must stay stable.
  - in_valid pulses during RUN must not be accepted.
  - Back-to-back transactions must each complete.
- Reset mid-RUN: assert rst at step 3 -> next cycle out_valid=0 and in_ready=1. A new operation after reset must produce a correct result.
